// File: rtl/tile_permuter_pkg.sv
// Shared types and helpers for the tile relayout engine.
package tile_permuter_pkg;

    typedef enum logic [1:0] {
        COPY     = 2'd0,
        XPOSE_BW = 2'd1,
        XPOSE_WC = 2'd2,
        RSVD     = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Elements per buffer word.
    function automatic int cs_of(input int data_width, input int elem_width);
        return data_width / elem_width;
    endfunction

endpackage

// File: rtl/tile_permuter_addr_fifo.sv
// Pending destination addresses, one per outstanding read, in issue order.
// Zero-latency head; push while full is accepted only together with a pop.
module tile_addr_fifo #(
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_dat,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] pop_dat,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign full    = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/tile_permuter.sv
// Streams a tile from layout (b,w,ct) to a mode-selected layout, one read per cycle.
// Write follows read data by one cycle; issue stalls while FIFO_DEPTH reads are outstanding.
module tile_permuter
    import tile_permuter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int ELEM_WIDTH = 16,
    parameter int DIM_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] src_base_addr,
    input  logic [ADDR_WIDTH-1:0] dst_base_addr,
    input  logic [DIM_WIDTH-1:0]  b_dim,
    input  logic [DIM_WIDTH-1:0]  w_dim,
    input  logic [DIM_WIDTH-1:0]  c_dim,
    input  logic [1:0]            mode,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_csb,
    input  logic [DATA_WIDTH-1:0] rd_dout,
    input  logic                  rd_dout_vld,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_din,
    output logic                  wr_csb
);
    localparam int CS    = cs_of(DATA_WIDTH, ELEM_WIDTH);
    localparam int CNT_W = 3 * DIM_WIDTH;
    localparam int AW    = ADDR_WIDTH;

    state_t                state_q, state_d;
    mode_t                 mode_q, mode_d;
    logic                  err_flag_q, err_flag_d;
    logic [AW-1:0]         src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [DIM_WIDTH-1:0]  b_dim_q, b_dim_d, w_dim_q, w_dim_d, ct_q, ct_d;
    logic [DIM_WIDTH-1:0]  w_idx_q, w_idx_d, ct_idx_q, ct_idx_d;
    logic [CNT_W-1:0]      total_q, total_d, iss_cnt_q, iss_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]         s_sb_q, s_sb_d, s_sw_q, s_sw_d;
    logic [AW-1:0]         d_sb_q, d_sb_d, d_sw_q, d_sw_d, d_sc_q, d_sc_d;
    logic [AW-1:0]         s_row_b_q, s_row_b_d, s_row_w_q, s_row_w_d, s_cur_q, s_cur_d;
    logic [AW-1:0]         d_row_b_q, d_row_b_d, d_row_w_q, d_row_w_d, d_cur_q, d_cur_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [AW-1:0]         rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic                  rd_csb_q, rd_csb_d, wr_csb_q, wr_csb_d;
    logic [DATA_WIDTH-1:0] wr_din_q, wr_din_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW-1:0]         fifo_head;
    logic [CNT_W-1:0]      wct;
    logic [AW-1:0]         bct;
    logic                  bad_cmd;

    tile_addr_fifo #(.ADDR_WIDTH(AW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (d_cur_q),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rd_addr = rd_addr_q;
    assign rd_csb  = rd_csb_q;
    assign wr_addr = wr_addr_q;
    assign wr_din  = wr_din_q;
    assign wr_csb  = wr_csb_q;

    always_comb begin
        state_d    = state_q;    mode_d     = mode_q;     err_flag_d = err_flag_q;
        src_base_d = src_base_q; dst_base_d = dst_base_q;
        b_dim_d    = b_dim_q;    w_dim_d    = w_dim_q;    ct_d       = ct_q;
        w_idx_d    = w_idx_q;    ct_idx_d   = ct_idx_q;
        total_d    = total_q;    iss_cnt_d  = iss_cnt_q;  wr_cnt_d   = wr_cnt_q;
        s_sb_d     = s_sb_q;     s_sw_d     = s_sw_q;
        d_sb_d     = d_sb_q;     d_sw_d     = d_sw_q;     d_sc_d     = d_sc_q;
        s_row_b_d  = s_row_b_q;  s_row_w_d  = s_row_w_q;  s_cur_d    = s_cur_q;
        d_row_b_d  = d_row_b_q;  d_row_w_d  = d_row_w_q;  d_cur_d    = d_cur_q;
        busy_d     = busy_q;     done_d     = 1'b0;       err_d      = 1'b0;
        rd_addr_d  = rd_addr_q;  rd_csb_d   = 1'b1;
        wr_addr_d  = wr_addr_q;  wr_din_d   = wr_din_q;   wr_csb_d   = 1'b1;
        fifo_push  = 1'b0;       fifo_pop   = 1'b0;

        wct     = CNT_W'(w_dim_q) * CNT_W'(ct_q);
        bct     = AW'(CNT_W'(b_dim_q) * CNT_W'(ct_q));
        bad_cmd = (b_dim == '0) || (w_dim == '0) || (c_dim == '0) ||
                  ((c_dim % DIM_WIDTH'(CS)) != '0) || (mode_t'(mode) == RSVD);

        // Returns outside RUN/DRAIN, or with nothing pending, are spurious and dropped.
        if ((state_q == RUN || state_q == DRAIN) && rd_dout_vld && !fifo_empty) begin
            fifo_pop  = 1'b1;
            wr_csb_d  = 1'b0;
            wr_addr_d = fifo_head;
            wr_din_d  = rd_dout;
            wr_cnt_d  = wr_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_base_d = src_base_addr;
                    dst_base_d = dst_base_addr;
                    b_dim_d    = b_dim;
                    w_dim_d    = w_dim;
                    ct_d       = c_dim / DIM_WIDTH'(CS);
                    mode_d     = mode_t'(mode);
                    err_flag_d = bad_cmd;
                    busy_d     = 1'b1;
                    state_d    = bad_cmd ? FIN : SETUP;
                end
            end
            SETUP: begin
                total_d = CNT_W'(b_dim_q) * wct;
                s_sb_d  = AW'(wct);
                s_sw_d  = AW'(ct_q);
                case (mode_q)
                    XPOSE_BW: begin d_sb_d = AW'(ct_q); d_sw_d = bct;       d_sc_d = AW'(1);       end
                    XPOSE_WC: begin d_sb_d = AW'(wct);  d_sw_d = AW'(1);    d_sc_d = AW'(w_dim_q); end
                    default:  begin d_sb_d = AW'(wct);  d_sw_d = AW'(ct_q); d_sc_d = AW'(1);       end
                endcase
                s_row_b_d = src_base_q; s_row_w_d = src_base_q; s_cur_d = src_base_q;
                d_row_b_d = dst_base_q; d_row_w_d = dst_base_q; d_cur_d = dst_base_q;
                iss_cnt_d = '0;
                wr_cnt_d  = '0;
                w_idx_d   = '0;
                ct_idx_d  = '0;
                state_d   = RUN;
            end
            RUN: begin
                if (!fifo_full) begin
                    rd_csb_d  = 1'b0;
                    rd_addr_d = s_cur_q;
                    fifo_push = 1'b1;
                    iss_cnt_d = iss_cnt_q + CNT_W'(1);
                    // Row bases absorb the outer strides so each step is a single add.
                    if (ct_idx_q != ct_q - DIM_WIDTH'(1)) begin
                        ct_idx_d = ct_idx_q + DIM_WIDTH'(1);
                        s_cur_d  = s_cur_q + AW'(1);
                        d_cur_d  = d_cur_q + d_sc_q;
                    end else if (w_idx_q != w_dim_q - DIM_WIDTH'(1)) begin
                        ct_idx_d  = '0;
                        w_idx_d   = w_idx_q + DIM_WIDTH'(1);
                        s_row_w_d = s_row_w_q + s_sw_q;
                        s_cur_d   = s_row_w_q + s_sw_q;
                        d_row_w_d = d_row_w_q + d_sw_q;
                        d_cur_d   = d_row_w_q + d_sw_q;
                    end else begin
                        ct_idx_d  = '0;
                        w_idx_d   = '0;
                        s_row_b_d = s_row_b_q + s_sb_q;
                        s_row_w_d = s_row_b_q + s_sb_q;
                        s_cur_d   = s_row_b_q + s_sb_q;
                        d_row_b_d = d_row_b_q + d_sb_q;
                        d_row_w_d = d_row_b_q + d_sb_q;
                        d_cur_d   = d_row_b_q + d_sb_q;
                    end
                    if (iss_cnt_q == total_q - CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_cnt_q == total_q && wr_csb_q) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                err_d   = err_flag_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;     mode_q     <= COPY;     err_flag_q <= 1'b0;
            src_base_q <= '0;       dst_base_q <= '0;
            b_dim_q    <= '0;       w_dim_q    <= '0;       ct_q       <= '0;
            w_idx_q    <= '0;       ct_idx_q   <= '0;
            total_q    <= '0;       iss_cnt_q  <= '0;       wr_cnt_q   <= '0;
            s_sb_q     <= '0;       s_sw_q     <= '0;
            d_sb_q     <= '0;       d_sw_q     <= '0;       d_sc_q     <= '0;
            s_row_b_q  <= '0;       s_row_w_q  <= '0;       s_cur_q    <= '0;
            d_row_b_q  <= '0;       d_row_w_q  <= '0;       d_cur_q    <= '0;
            busy_q     <= 1'b0;     done_q     <= 1'b0;     err_q      <= 1'b0;
            rd_addr_q  <= '0;       rd_csb_q   <= 1'b1;
            wr_addr_q  <= '0;       wr_din_q   <= '0;       wr_csb_q   <= 1'b1;
        end else begin
            state_q    <= state_d;    mode_q     <= mode_d;     err_flag_q <= err_flag_d;
            src_base_q <= src_base_d; dst_base_q <= dst_base_d;
            b_dim_q    <= b_dim_d;    w_dim_q    <= w_dim_d;    ct_q       <= ct_d;
            w_idx_q    <= w_idx_d;    ct_idx_q   <= ct_idx_d;
            total_q    <= total_d;    iss_cnt_q  <= iss_cnt_d;  wr_cnt_q   <= wr_cnt_d;
            s_sb_q     <= s_sb_d;     s_sw_q     <= s_sw_d;
            d_sb_q     <= d_sb_d;     d_sw_q     <= d_sw_d;     d_sc_q     <= d_sc_d;
            s_row_b_q  <= s_row_b_d;  s_row_w_q  <= s_row_w_d;  s_cur_q    <= s_cur_d;
            d_row_b_q  <= d_row_b_d;  d_row_w_q  <= d_row_w_d;  d_cur_q    <= d_cur_d;
            busy_q     <= busy_d;     done_q     <= done_d;     err_q      <= err_d;
            rd_addr_q  <= rd_addr_d;  rd_csb_q   <= rd_csb_d;
            wr_addr_q  <= wr_addr_d;  wr_din_q   <= wr_din_d;   wr_csb_q   <= wr_csb_d;
        end
    end

endmodule

// File: tb/tb_tile_permuter.sv
// Directed bench for tile_permuter with a latency-programmable two-port buffer model.
module tb_tile_permuter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  src_base_addr, dst_base_addr, b_dim, w_dim, c_dim;
    logic [1:0]  mode;
    logic        start;
    logic        busy, done, err;
    logic [7:0]  rd_addr, wr_addr;
    logic        rd_csb, wr_csb;
    logic [63:0] rd_dout, wr_din;
    logic        rd_dout_vld;

    always #5 clk = ~clk;

    tile_permuter dut (
        .clk(clk), .rst_n(rst_n),
        .src_base_addr(src_base_addr), .dst_base_addr(dst_base_addr),
        .b_dim(b_dim), .w_dim(w_dim), .c_dim(c_dim), .mode(mode), .start(start),
        .busy(busy), .done(done), .err(err),
        .rd_addr(rd_addr), .rd_csb(rd_csb), .rd_dout(rd_dout), .rd_dout_vld(rd_dout_vld),
        .wr_addr(wr_addr), .wr_din(wr_din), .wr_csb(wr_csb)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [7:0] a);
        return {a, 8'h11, a, 8'h22, a, 8'h33, a, 8'h44};
    endfunction

    // Buffer model: reads sampled mid-cycle are taken on the next edge and
    // returned lat cycles later, in order.
    logic [63:0] mem [256];
    logic [63:0] rq_dat [$];
    int          rq_due [$];
    int          lat = 1;
    int          ncyc = 0;
    int          rd_seen = 0;
    int          vld_given = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
        rd_dout     = '0;
        rd_dout_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_csb === 1'b0) begin
                rq_dat.push_back(mem[rd_addr]);
                rq_due.push_back(ncyc + lat);
                rd_seen++;
            end
            if (wr_csb === 1'b0) mem[wr_addr] = wr_din;
            @(posedge clk);
            ncyc++;
            #1;
            if (rq_due.size() > 0 && rq_due[0] <= ncyc) begin
                rd_dout = rq_dat.pop_front();
                void'(rq_due.pop_front());
                rd_dout_vld = 1'b1;
                vld_given++;
            end else begin
                rd_dout     = '0;
                rd_dout_vld = 1'b0;
            end
        end
    end

    logic [7:0] ra_q [$];

    task automatic run_cmd(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] bd,
                           input logic [7:0] wd, input logic [7:0] cd, input logic [1:0] md,
                           input int l, output int nwr, output int ndone, output int nerr,
                           output int maxrun, output int maxout, output logic busy1);
        int  run;
        int  tail;
        bit  seen;
        nwr = 0; ndone = 0; nerr = 0; maxrun = 0; maxout = 0; run = 0; tail = 0; seen = 0;
        busy1 = 1'b0;
        ra_q.delete();
        lat = l;
        @(posedge clk); #1;
        src_base_addr = src; dst_base_addr = dst;
        b_dim = bd; w_dim = wd; c_dim = cd; mode = md; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 0) busy1 = busy;
            if (rd_csb === 1'b0) begin
                ra_q.push_back(rd_addr);
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (wr_csb === 1'b0) nwr++;
            if (rd_seen - vld_given > maxout) maxout = rd_seen - vld_given;
            if (done === 1'b1) begin ndone++; seen = 1; end
            if (err === 1'b1) nerr++;
            if (seen) tail++;
            if (tail > 3) break;
        end
    endtask

    task automatic run_bad(input string tag, input logic [7:0] bd, input logic [7:0] wd,
                           input logic [7:0] cd, input logic [1:0] md);
        int acc;
        acc = 0;
        @(posedge clk); #1;
        src_base_addr = 8'h00; dst_base_addr = 8'h40;
        b_dim = bd; w_dim = wd; c_dim = cd; mode = md; start = 1'b1;
        if (rd_csb === 1'b0 || wr_csb === 1'b0) acc++;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy1"}, busy, 1);
        chk({tag, "_done1"}, done, 0);
        if (rd_csb === 1'b0 || wr_csb === 1'b0) acc++;
        @(negedge clk);
        chk({tag, "_done2"}, done, 1);
        chk({tag, "_err2"}, err, 1);
        chk({tag, "_busy2"}, busy, 0);
        if (rd_csb === 1'b0 || wr_csb === 1'b0) acc++;
        @(negedge clk);
        chk({tag, "_done3"}, done, 0);
        if (rd_csb === 1'b0 || wr_csb === 1'b0) acc++;
        chk({tag, "_no_access"}, acc, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int   nwr, nd, ne, mr, mo, rs0, vg0, acc;
    logic b1;
    bit   got2;

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 2'd0;
        src_base_addr = '0; dst_base_addr = '0; b_dim = '0; w_dim = '0; c_dim = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_csb", rd_csb, 1);
        chk("rst_wr_csb", wr_csb, 1);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_din", wr_din, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // COPY b=2 w=3 c=8 -> 12 words, dst[0x40+i] = src[i]
        run_cmd(8'h00, 8'h40, 8'd2, 8'd3, 8'd8, 2'd0, 1, nwr, nd, ne, mr, mo, b1);
        chk("copy_busy", b1, 1);
        chk("copy_nwr", nwr, 12);
        chk("copy_done", nd, 1);
        chk("copy_err", ne, 0);
        for (int i = 0; i < 12; i++) chk("copy_data", mem[8'h40 + i], pat(8'(i)));

        // XPOSE_BW: (b,w,ct) from 0x00+b*6+w*2+ct to 0x80+w*4+b*2+ct
        run_cmd(8'h00, 8'h80, 8'd2, 8'd3, 8'd8, 2'd1, 1, nwr, nd, ne, mr, mo, b1);
        chk("bw_nwr", nwr, 12);
        chk("bw_done", nd, 1);
        chk("bw_err", ne, 0);
        chk("bw_back_to_back", mr, 12);
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < 3; w++)
                for (int ct = 0; ct < 2; ct++)
                    chk("bw_data", mem[8'h80 + w*4 + b*2 + ct], pat(8'(b*6 + w*2 + ct)));

        // XPOSE_WC b=1 w=4 c=12, latency 3: (0,w,ct) from 0x10+w*3+ct to 0xC0+ct*4+w
        run_cmd(8'h10, 8'hC0, 8'd1, 8'd4, 8'd12, 2'd2, 3, nwr, nd, ne, mr, mo, b1);
        chk("wc_nwr", nwr, 12);
        chk("wc_done", nd, 1);
        chk("wc_err", ne, 0);
        chk("wc_max_out_le4", (mo <= 4), 1);
        chk("wc_issue_stalled", (mr < 12), 1);
        for (int w = 0; w < 4; w++)
            for (int ct = 0; ct < 3; ct++)
                chk("wc_data", mem[8'hC0 + ct*4 + w], pat(8'(8'h10 + w*3 + ct)));

        run_bad("bad_c6", 8'd2, 8'd3, 8'd6, 2'd0);
        run_bad("bad_b0", 8'd0, 8'd3, 8'd8, 2'd0);
        run_bad("bad_m3", 8'd2, 8'd3, 8'd8, 2'd3);

        // Address wrap: reads 0xFC..0xFF
        run_cmd(8'hFC, 8'h50, 8'd1, 8'd2, 8'd8, 2'd0, 1, nwr, nd, ne, mr, mo, b1);
        chk("wrap_nrd", ra_q.size(), 4);
        chk("wrap_done", nd, 1);
        chk("wrap_err", ne, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < ra_q.size()) chk("wrap_rd_addr", ra_q[i], 8'(8'hFC + i));
            chk("wrap_data", mem[8'h50 + i], pat(8'(8'hFC + i)));
        end

        // Abort mid-RUN with two reads in flight; late returns must be ignored.
        lat = 6;
        rs0 = rd_seen;
        @(posedge clk); #1;
        src_base_addr = 8'h00; dst_base_addr = 8'h60;
        b_dim = 8'd2; w_dim = 8'd3; c_dim = 8'd8; mode = 2'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got2 = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #3;
            if (rd_seen - rs0 >= 2) begin got2 = 1; break; end
        end
        chk("abort_reached_2_out", got2, 1);
        rst_n = 1'b0;
        #2;
        chk("abort_rd_csb", rd_csb, 1);
        chk("abort_busy", busy, 0);
        vg0 = vld_given;
        @(negedge clk); #2;
        rst_n = 1'b1;
        acc = 0;
        nd  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_csb === 1'b0 || rd_csb === 1'b0) acc++;
            if (done === 1'b1) nd++;
        end
        chk("abort_late_vld_seen", (vld_given - vg0 >= 2), 1);
        chk("abort_no_access", acc, 0);
        chk("abort_no_done", nd, 0);

        // Fresh COPY after abort
        run_cmd(8'h00, 8'h70, 8'd2, 8'd3, 8'd8, 2'd0, 1, nwr, nd, ne, mr, mo, b1);
        chk("post_nwr", nwr, 12);
        chk("post_done", nd, 1);
        chk("post_err", ne, 0);
        for (int i = 0; i < 12; i++) chk("post_data", mem[8'h70 + i], pat(8'(i)));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
